dbus_arbiter: RTL and testbench

Two-master, one-slave data-bus arbiter sharing the single-port data RAM between the RISC-V core load/store port (M0) and the CNN accelerator DMA port (M1). It replaces direct core-to-RAM wiring so the accelerator can fetch feature maps and weights without contending on the read-data bus. Single-beat transactions, one grant per cycle, synchronous-read slave with 1-cycle read latency. Fixed CPU priority, bounded by an M1 burst lock and an M1 anti-starvation counter.

---
 rtl/dbus_arbiter.sv | 136 +++++++++++++
 tb/tb_dbus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master, one-slave data-bus arbiter: RISC-V load/store port (M0) and CNN DMA port (M1)
// sharing a single-port synchronous-read RAM. Fixed M0 priority, bounded by M1 burst lock and starvation.
module dbus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_sel,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_sel,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          s_req,
  output logic          s_we,
  output logic [3:0]    s_sel,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_tag_q, rd_tag_d;

  logic keep_m1;
  logic starved;
  logic gnt0;
  logic gnt1;

  always_comb begin
    keep_m1 = (owner_q == OWN_M1) && m1_lock && m1_req &&
              ((burst_q < BW'(MAX_BURST)) || !m0_req);
    starved = m1_req && (starve_q == SW'(STARVE_LIMIT));
    // Grants are gated by rst so nothing strobes while reset is held.
    gnt1    = !rst && (keep_m1 || starved || (m1_req && !m0_req));
    gnt0    = !rst && m0_req && !keep_m1 && !starved;
  end

  always_comb begin
    owner_d   = IDLE;
    burst_d   = '0;
    starve_d  = '0;
    rd_pend_d = 1'b0;
    rd_tag_d  = 1'b0;
    if (gnt1) begin
      owner_d = OWN_M1;
      if (owner_q != OWN_M1) begin
        burst_d = BW'(1);
      end else if (burst_q < BW'(MAX_BURST)) begin
        burst_d = burst_q + BW'(1);
      end else begin
        burst_d = burst_q;
      end
      rd_pend_d = !m1_we;
      rd_tag_d  = 1'b1;
    end else if (gnt0) begin
      owner_d   = OWN_M0;
      rd_pend_d = !m0_we;
      rd_tag_d  = 1'b0;
    end
    if (m1_req && !gnt1) begin
      starve_d = (starve_q < SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= IDLE;
      burst_q   <= '0;
      starve_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (gnt0) begin
      s_req   = 1'b1;
      s_we    = m0_we;
      s_sel   = m0_sel;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (gnt1) begin
      s_req   = 1'b1;
      s_we    = m1_we;
      s_sel   = m1_sel;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_pend_q && !rd_tag_q;
  assign m1_rvalid = rd_pend_q && rd_tag_q;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: a priority/credit reference model predicts each cycle's
// grant and read return; a negedge monitor pops and compares against the DUT.
module tb_dbus_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 8;
  localparam int STV  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 0, m0_we = 0;
  logic [3:0]    m0_sel = '0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [3:0]    m1_sel = '0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          s_req, s_we;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;

  always #5 clk = ~clk;

  dbus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .STARVE_LIMIT(STV)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata)
  );

  // Synchronous-read RAM behind the slave port.
  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (s_req) begin
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) ram[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end else begin
        s_rdata <= ram[s_addr[9:2]];
      end
    end
  end

  typedef struct {
    logic        g0, g1, we;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
  } exp_t;
  typedef struct {
    logic        tag;
    logic [31:0] data;
    int          due;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;

  // Reference model state: who was served last, length of current M1 run, M1 waiting time.
  int last_own = 0;
  int run = 0;
  int wait_c = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    exp_t e;
    rd_t  r;
    int   win;
    bit   keep, starving;
    keep     = (last_own == 2) && m1_lock && m1_req && (run < MAXB || !m0_req);
    starving = m1_req && (wait_c >= STV);
    if (keep || starving) win = 2;
    else if (m0_req)      win = 1;
    else if (m1_req)      win = 2;
    else                  win = 0;
    e.g0 = (win == 1); e.g1 = (win == 2);
    e.we = 0; e.sel = '0; e.addr = '0; e.wdata = '0;
    if (win == 1) begin
      e.we = m0_we; e.sel = m0_sel; e.addr = m0_addr; e.wdata = m0_wdata;
    end else if (win == 2) begin
      e.we = m1_we; e.sel = m1_sel; e.addr = m1_addr; e.wdata = m1_wdata;
    end
    if (win != 0) begin
      if (e.we) begin
        for (int b = 0; b < 4; b++)
          if (e.sel[b]) ref_mem[e.addr[9:2]][8*b +: 8] = e.wdata[8*b +: 8];
      end else begin
        r.tag = (win == 2); r.data = ref_mem[e.addr[9:2]]; r.due = cyc + 1;
        rd_q.push_back(r);
      end
    end
    if (win == 2) run = (last_own == 2) ? ((run + 1 > MAXB) ? MAXB : run + 1) : 1;
    else          run = 0;
    if (m1_req && win != 2) wait_c = (wait_c + 1 > STV) ? STV : wait_c + 1;
    else                    wait_c = 0;
    last_own = win;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    rd_t  r;
    logic [31:0] rd;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({m0_gnt, m1_gnt, s_req, s_we, s_sel, s_addr, s_wdata} !==
            {e.g0, e.g1, e.g0 | e.g1, e.we, e.sel, e.addr, e.wdata}) begin
          failures++;
          $display("FAIL bus cyc=%0d got g0=%b g1=%b req=%b we=%b sel=%h addr=%h wd=%h exp g0=%b g1=%b we=%b sel=%h addr=%h wd=%h",
                   cyc, m0_gnt, m1_gnt, s_req, s_we, s_sel, s_addr, s_wdata,
                   e.g0, e.g1, e.we, e.sel, e.addr, e.wdata);
        end
      end
      if (m0_rvalid || m1_rvalid) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rvalid_unexpected cyc=%0d got m0_rvalid=%b m1_rvalid=%b exp none", cyc, m0_rvalid, m1_rvalid);
        end else begin
          r  = rd_q.pop_front();
          rd = m1_rvalid ? m1_rdata : m0_rdata;
          if (r.due != cyc || (m0_rvalid && m1_rvalid) || m1_rvalid != r.tag || rd !== r.data) begin
            failures++;
            $display("FAIL rdata cyc=%0d got m0v=%b m1v=%b data=%h exp due=%0d m1=%b data=%h",
                     cyc, m0_rvalid, m1_rvalid, rd, r.due, r.tag, r.data);
          end
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r = rd_q.pop_front();
        checks++; failures++;
        $display("FAIL rvalid_missing cyc=%0d got none exp m1=%b data=%h due=%0d", cyc, r.tag, r.data, r.due);
      end
    end
  end

  task automatic chk_zero(input string name);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_req, s_we, s_sel, s_addr, s_wdata} !== '0) begin
      failures++;
      $display("FAIL %s got g0=%b g1=%b rv0=%b rv1=%b req=%b we=%b sel=%h addr=%h wd=%h exp all 0",
               name, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_req, s_we, s_sel, s_addr, s_wdata);
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_sel = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_sel = '0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  task automatic drv0(input bit req, input bit we, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_sel = sel; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drv1(input bit req, input bit we, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d, input bit lk);
    m1_req = req; m1_we = we; m1_sel = sel; m1_addr = a; m1_wdata = d; m1_lock = lk;
  endtask

  // Asserts reset mid-cycle with both masters requesting; outputs must drop at once.
  task automatic do_reset();
    drv0(1, 0, 4'hF, 32'h10, 0);
    drv1(1, 0, 4'hF, 32'h20, 0, 1);
    rst = 1'b1;
    #1;
    chk_zero("reset_immediate");
    rd_q.delete();
    exp_q.delete();
    last_own = 0; run = 0; wait_c = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_held");
    idle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    idle();
    @(posedge clk); #1;
    do_reset();

    // Idle after reset
    repeat (2) step();

    // Simultaneous requests: M0 wins, M1 served afterwards
    drv0(1, 0, 4'hF, 32'h100, 0);
    drv1(1, 0, 4'hF, 32'h200, 0, 0);
    step();
    drv0(0, 0, 4'h0, 0, 0);
    step();
    idle(); step();

    // Starvation: both held
    drv0(1, 0, 4'hF, 32'h104, 0);
    drv1(1, 0, 4'hF, 32'h204, 0, 0);
    repeat (7) step();
    idle(); step();

    // Locked burst, M0 arrives mid-burst, then lock without competition
    drv1(1, 0, 4'hF, 32'h300, 0, 1);
    repeat (3) step();
    drv0(1, 0, 4'hF, 32'h108, 0);
    repeat (10) step();
    drv0(0, 0, 4'h0, 0, 0);
    repeat (12) step();
    idle(); step();

    // Write then read back through the other master
    drv1(1, 1, 4'hF, 32'h40, 32'hDEADBEEF, 0);
    step();
    drv1(0, 0, 4'h0, 0, 0, 0);
    drv0(1, 0, 4'hF, 32'h40, 0);
    step();
    idle(); repeat (2) step();

    // Reset with an M1 read outstanding; counters must be clear afterwards
    drv1(1, 0, 4'hF, 32'h80, 0, 0);
    step();
    do_reset();
    drv0(1, 0, 4'hF, 32'h84, 0);
    drv1(1, 0, 4'hF, 32'h88, 0, 1);
    step();
    idle(); repeat (2) step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drv0($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
      drv1($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, $urandom_range(0, 99) < 75);
      step();
    end
    idle(); repeat (3) step();

    checks++;
    if (rd_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got rd_left=%0d exp_left=%0d exp 0", rd_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
